// File: rtl/counter_pkg.sv
// Shared definitions for the modulo counter: mode encodings and the
// elaboration-time parameter legality check.
package counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Widths are capped so the 2**n terms stay inside a 32-bit int.
    function automatic bit params_legal(
        input int width,
        input int max_val,
        input int step_w,
        input int reset_value
    );
        return (width >= 1) && (width <= 30) &&
               (step_w >= 1) && (step_w <= 30) &&
               (max_val >= 0) && (max_val <= (2 ** width) - 1) &&
               ((2 ** step_w) - 1 <= max_val + 1) &&
               (reset_value >= 0) && (reset_value <= max_val);
    endfunction

endpackage

// File: rtl/mod_counter_next.sv
// Combinational next-value logic for mod_counter: raw signed sum, wrap or
// saturate correction, reinit override and boundary-crossing flags.
module mod_counter_next
    import counter_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 10,
    parameter int STEP_W  = 2
) (
    input  logic [WIDTH-1:0]  value,
    input  logic [STEP_W-1:0] incr,
    input  logic              incr_valid,
    input  logic [STEP_W-1:0] decr,
    input  logic              decr_valid,
    input  logic              reinit,
    input  logic [WIDTH-1:0]  initial_value,
    input  logic              mode,
    output logic [WIDTH-1:0]  value_next,
    output logic              ovf_d,
    output logic              unf_d
);

    // Two guard bits: one for the carry above 2^WIDTH-1, one for the sign.
    localparam int SW = WIDTH + 2;
    localparam logic signed [SW-1:0] MAX_S  = SW'(MAX_VAL);
    localparam logic signed [SW-1:0] SPAN_S = SW'(MAX_VAL + 1);
    localparam logic [WIDTH-1:0]     MAX_W  = WIDTH'(MAX_VAL);

    logic signed [SW-1:0] inc_s;
    logic signed [SW-1:0] dec_s;
    logic signed [SW-1:0] sum_s;
    logic signed [SW-1:0] fix_s;

    always_comb begin
        inc_s      = '0;
        dec_s      = '0;
        ovf_d      = 1'b0;
        unf_d      = 1'b0;
        value_next = '0;
        if (incr_valid) inc_s = $signed({{(SW-STEP_W){1'b0}}, incr});
        if (decr_valid) dec_s = $signed({{(SW-STEP_W){1'b0}}, decr});
        sum_s = $signed({2'b00, value}) + inc_s - dec_s;
        fix_s = sum_s;

        if (reinit) begin
            // Silent clamp: an out-of-range load never raises a pulse.
            value_next = (initial_value > MAX_W) ? MAX_W : initial_value;
        end else begin
            if (sum_s > MAX_S) begin
                ovf_d = 1'b1;
                fix_s = (mode == MODE_SAT) ? MAX_S : sum_s - SPAN_S;
            end else if (sum_s < 0) begin
                unf_d = 1'b1;
                fix_s = (mode == MODE_SAT) ? '0 : sum_s + SPAN_S;
            end
            value_next = fix_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Modulo up/down counter with wrap or saturate behaviour: value and
// boundary-pulse registers around the combinational next-value block.
module mod_counter
    import counter_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int MAX_VAL     = 10,
    parameter int STEP_W      = 2,
    parameter int RESET_VALUE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [STEP_W-1:0] incr,
    input  logic              incr_valid,
    input  logic [STEP_W-1:0] decr,
    input  logic              decr_valid,
    input  logic              reinit,
    input  logic [WIDTH-1:0]  initial_value,
    input  logic              mode,
    output logic [WIDTH-1:0]  value,
    output logic [WIDTH-1:0]  value_next,
    output logic              at_max,
    output logic              at_zero,
    output logic              ovf,
    output logic              unf
);

    if (!params_legal(WIDTH, MAX_VAL, STEP_W, RESET_VALUE)) begin : g_bad_params
        $error("mod_counter: illegal WIDTH/MAX_VAL/STEP_W/RESET_VALUE combination");
    end

    localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] nxt_value;
    logic             ovf_d;
    logic             unf_d;

    mod_counter_next #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .STEP_W  (STEP_W)
    ) u_next (
        .value         (value),
        .incr          (incr),
        .incr_valid    (incr_valid),
        .decr          (decr),
        .decr_valid    (decr_valid),
        .reinit        (reinit),
        .initial_value (initial_value),
        .mode          (mode),
        .value_next    (nxt_value),
        .ovf_d         (ovf_d),
        .unf_d         (unf_d)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            value <= RESET_W;
            ovf   <= 1'b0;
            unf   <= 1'b0;
        end else begin
            value <= nxt_value;
            ovf   <= ovf_d;
            unf   <= unf_d;
        end
    end

    // During reset the exported next value mirrors the held reset value.
    assign value_next = rst ? nxt_value : RESET_W;
    assign at_max     = (value == MAX_W);
    assign at_zero    = (value == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Directed bench for mod_counter: default instance plus a wide instance,
// expected results queued per step and compared after the clock edge.
module tb_mod_counter;

    logic clk = 1'b0;
    logic rst;

    logic [1:0] n_incr, n_decr;
    logic       n_incr_valid, n_decr_valid, n_reinit, n_mode;
    logic [3:0] n_initial_value, n_value, n_value_next;
    logic       n_at_max, n_at_zero, n_ovf, n_unf;

    logic [3:0] w_incr, w_decr;
    logic       w_incr_valid, w_decr_valid, w_reinit, w_mode;
    logic [7:0] w_initial_value, w_value, w_value_next;
    logic       w_at_max, w_at_zero, w_ovf, w_unf;

    typedef struct {
        string tag;
        int    value;
        bit    ovf;
        bit    unf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mod_counter dut_n (
        .clk           (clk),
        .rst           (rst),
        .incr          (n_incr),
        .incr_valid    (n_incr_valid),
        .decr          (n_decr),
        .decr_valid    (n_decr_valid),
        .reinit        (n_reinit),
        .initial_value (n_initial_value),
        .mode          (n_mode),
        .value         (n_value),
        .value_next    (n_value_next),
        .at_max        (n_at_max),
        .at_zero       (n_at_zero),
        .ovf           (n_ovf),
        .unf           (n_unf)
    );

    mod_counter #(
        .WIDTH       (8),
        .MAX_VAL     (199),
        .STEP_W      (4),
        .RESET_VALUE (0)
    ) dut_w (
        .clk           (clk),
        .rst           (rst),
        .incr          (w_incr),
        .incr_valid    (w_incr_valid),
        .decr          (w_decr),
        .decr_valid    (w_decr_valid),
        .reinit        (w_reinit),
        .initial_value (w_initial_value),
        .mode          (w_mode),
        .value         (w_value),
        .value_next    (w_value_next),
        .at_max        (w_at_max),
        .at_zero       (w_at_zero),
        .ovf           (w_ovf),
        .unf           (w_unf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic idle_n();
        n_incr_valid = 1'b0; n_decr_valid = 1'b0; n_reinit = 1'b0;
        n_incr = '0; n_decr = '0; n_initial_value = '0;
    endtask

    task automatic idle_w();
        w_incr_valid = 1'b0; w_decr_valid = 1'b0; w_reinit = 1'b0;
        w_incr = '0; w_decr = '0; w_initial_value = '0;
    endtask

    // One step on the default instance: drive, check value_next, clock, check.
    task automatic cyc_n(input string tag, input bit md, input bit ri, input int iv,
                         input bit ivld, input int inc, input bit dvld, input int dec,
                         input int ev, input bit eo, input bit eu);
        exp_t e;
        n_mode = md; n_reinit = ri; n_initial_value = 4'(iv);
        n_incr_valid = ivld; n_incr = 2'(inc);
        n_decr_valid = dvld; n_decr = 2'(dec);
        sb.push_back('{tag, ev, eo, eu});
        #1;
        chk({tag, ".value_next"}, 32'(n_value_next), 32'(ev));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".value"},   32'(n_value),   32'(e.value));
        chk({e.tag, ".ovf"},     32'(n_ovf),     32'(e.ovf));
        chk({e.tag, ".unf"},     32'(n_unf),     32'(e.unf));
        chk({e.tag, ".at_max"},  32'(n_at_max),  32'(e.value == 10));
        chk({e.tag, ".at_zero"}, 32'(n_at_zero), 32'(e.value == 0));
    endtask

    task automatic cyc_w(input string tag, input bit md, input bit ri, input int iv,
                         input bit ivld, input int inc, input bit dvld, input int dec,
                         input int ev, input bit eo, input bit eu);
        exp_t e;
        w_mode = md; w_reinit = ri; w_initial_value = 8'(iv);
        w_incr_valid = ivld; w_incr = 4'(inc);
        w_decr_valid = dvld; w_decr = 4'(dec);
        sb.push_back('{tag, ev, eo, eu});
        #1;
        chk({tag, ".value_next"}, 32'(w_value_next), 32'(ev));
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({e.tag, ".value"},   32'(w_value),   32'(e.value));
        chk({e.tag, ".ovf"},     32'(w_ovf),     32'(e.ovf));
        chk({e.tag, ".unf"},     32'(w_unf),     32'(e.unf));
        chk({e.tag, ".at_max"},  32'(w_at_max),  32'(e.value == 199));
        chk({e.tag, ".at_zero"}, 32'(w_at_zero), 32'(e.value == 0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        idle_n(); idle_w();
        n_mode = 1'b0; w_mode = 1'b0;
        n_incr_valid = 1'b1; n_incr = 2'd3;
        w_incr_valid = 1'b1; w_incr = 4'd9;
        #2;
        chk("rst.value",      32'(n_value),      32'd0);
        chk("rst.value_next", 32'(n_value_next), 32'd0);
        chk("rst.at_zero",    32'(n_at_zero),    32'd1);
        chk("rst.at_max",     32'(n_at_max),     32'd0);
        chk("rst.ovf",        32'(n_ovf),        32'd0);
        chk("rst.unf",        32'(n_unf),        32'd0);
        chk("rst.w_value",    32'(w_value),      32'd0);
        chk("rst.w_next",     32'(w_value_next), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_hold.value",   32'(n_value), 32'd0);
        chk("rst_hold.w_value", 32'(w_value), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle_n(); idle_w();

        // reset mid-operation, then reload and count
        cyc_n("load6",   0, 1, 6, 0, 0, 0, 0, 6, 0, 0);
        #3 rst = 1'b0;
        #1;
        chk("mid_rst.value",      32'(n_value),      32'd0);
        chk("mid_rst.value_next", 32'(n_value_next), 32'd0);
        chk("mid_rst.at_zero",    32'(n_at_zero),    32'd1);
        #1 rst = 1'b1;
        cyc_n("reinit4", 0, 1, 4, 0, 0, 0, 0, 4, 0, 0);
        cyc_n("incr2",   0, 0, 0, 1, 2, 0, 0, 6, 0, 0);
        cyc_n("decr1",   0, 0, 0, 0, 0, 1, 1, 5, 0, 0);

        // wrap mode crossings
        cyc_n("load9",      0, 1, 9, 0, 0, 0, 0, 9, 0, 0);
        cyc_n("wrap_ovf",   0, 0, 0, 1, 3, 0, 0, 1, 1, 0);
        cyc_n("wrap_idle",  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        cyc_n("wrap_unf",   0, 0, 0, 0, 0, 1, 3, 9, 0, 1);
        cyc_n("wrap_idle2", 0, 0, 0, 0, 0, 0, 0, 9, 0, 0);

        // saturate mode, switched on the same edge
        cyc_n("sat_ovf",  1, 0, 0, 1, 3, 0, 0, 10, 1, 0);
        cyc_n("sat_hold", 1, 0, 0, 1, 1, 0, 0, 10, 1, 0);
        cyc_n("load1",    1, 1, 1, 0, 0, 0, 0, 1, 0, 0);
        cyc_n("sat_unf",  1, 0, 0, 0, 0, 1, 3, 0, 0, 1);
        cyc_n("sat_idle", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // exact boundaries in wrap mode
        cyc_n("load10",        0, 1, 10, 0, 0, 0, 0, 10, 0, 0);
        cyc_n("wrap_edge_ovf", 0, 0, 0,  1, 1, 0, 0, 0,  1, 0);
        cyc_n("wrap_edge_unf", 0, 0, 0,  0, 0, 1, 1, 10, 0, 1);
        cyc_n("sat_inrange",   1, 0, 0,  0, 0, 1, 3, 7,  0, 0);

        // reinit priority and silent clamp
        cyc_n("reinit_prio",  0, 1, 2,  1, 2, 1, 1, 2,  0, 0);
        cyc_n("reinit_clamp", 0, 1, 15, 1, 3, 0, 0, 10, 0, 0);

        // equal increments cancel; idle holds
        cyc_n("load5",   0, 1, 5, 0, 0, 0, 0, 5, 0, 0);
        cyc_n("both_eq", 0, 0, 0, 1, 3, 1, 3, 5, 0, 0);
        for (int i = 0; i < 3; i++)
            cyc_n("idle_hold", 0, 0, 0, 0, 0, 0, 0, 5, 0, 0);

        // reset aborts a pending pulse
        cyc_n("load10b",   0, 1, 10, 0, 0, 0, 0, 10, 0, 0);
        cyc_n("pre_abort", 0, 0, 0,  1, 1, 0, 0, 0,  1, 0);
        #3 rst = 1'b0;
        #1;
        chk("abort.ovf",   32'(n_ovf),   32'd0);
        chk("abort.unf",   32'(n_unf),   32'd0);
        chk("abort.value", 32'(n_value), 32'd0);
        #1 rst = 1'b1;
        cyc_n("wrap_unf3", 0, 0, 0, 0, 0, 1, 3, 8, 0, 1);
        idle_n();

        // wide instance
        cyc_w("w_load195",  0, 1, 195, 0, 0,  0, 0,  195, 0, 0);
        cyc_w("w_wrap_ovf", 0, 0, 0,   1, 15, 0, 0,  10,  1, 0);
        cyc_w("w_wrap_unf", 0, 0, 0,   0, 0,  1, 15, 195, 0, 1);
        cyc_w("w_sat_ovf",  1, 0, 0,   1, 15, 0, 0,  199, 1, 0);
        cyc_w("w_idle",     1, 0, 0,   0, 0,  0, 0,  199, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
